// File: rtl/cmd_uart_pkg.sv
// Shared types and constants for the host-side command UART.
// Contents:
//   uart_state_t - IDLE/START/DATA/STOP state encoding used by the RX and TX FSMs
//   FRAME_BITS   - bits per 8N1 frame (start + 8 data + stop)
//   DATA_BITS    - data bits per frame
package cmd_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = FRAME_BITS - 2;

endpackage

// File: rtl/uart_tx.sv
// 8N1 serializer. A trmt pulse while idle latches tx_data; TX goes low
// from the next cycle. Each frame bit lasts BAUD_DIV cycles. tx_done
// pulses in the last cycle of the stop bit, and the FSM is already IDLE in
// that cycle, so a trmt in that cycle starts the next frame back-to-back.
// Ports:
//   clk     in   1  system clock
//   rst_n   in   1  asynchronous active-low reset
//   tx_data in   8  byte to send, sampled when trmt is accepted
//   trmt    in   1  one-cycle transmit request (ignored while busy)
//   TX      out  1  serial line, idle high (registered)
//   tx_done out  1  one-cycle end-of-frame pulse (registered)
module uart_tx
  import cmd_uart_pkg::*;
#(
  parameter int BAUD_DIV = 1736
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       TX,
  output logic       tx_done
);

  localparam int CNT_W = $clog2(BAUD_DIV);

  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; the TX value for the next bit is prepared one cycle early.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (trmt) begin
          sh_d    = tx_data;
          tx_d    = 1'b0;
          cnt_d   = CNT_W'(BAUD_DIV - 1);
          state_d = START;
        end else begin
          tx_d = 1'b1;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          tx_d    = sh_q[0];
          sh_d    = {1'b0, sh_q[7:1]};
          bit_d   = 3'd0;
          cnt_d   = CNT_W'(BAUD_DIV - 1);
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
            // Stop bit is one cycle short: its last cycle is spent in IDLE
            // with tx_done high.
            tx_d    = 1'b1;
            cnt_d   = CNT_W'(BAUD_DIV - 2);
            state_d = STOP;
          end else begin
            tx_d  = sh_q[0];
            sh_d  = {1'b0, sh_q[7:1]};
            bit_d = bit_q + 3'd1;
            cnt_d = CNT_W'(BAUD_DIV - 1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign TX      = tx_q;
  assign tx_done = done_q;

endmodule

// File: rtl/cmd_uart_if.sv
// Host-side serial front end of the command/config unit. Receives 8N1
// bytes on RX, pairs them high-then-low into a 16-bit command with a
// cmd_rdy handshake, and transmits response bytes on TX via uart_tx.
// Optional feature macro: CMD_TIMEOUT_EN - when defined, a pending high
// byte is discarded if no low byte completes within TIMEOUT_BITS bit-times.
// Ports:
//   clk         in   1   system clock
//   rst_n       in   1   asynchronous active-low reset
//   RX          in   1   async serial input, idle high
//   TX          out  1   serial output, idle high
//   cmd         out  16  assembled command {first byte, second byte}
//   cmd_rdy     out  1   command valid, held until clr_cmd_rdy
//   clr_cmd_rdy in   1   consumer done, clears cmd_rdy
//   resp        in   8   response byte
//   send_resp   in   1   one-cycle transmit request
//   resp_sent   out  1   one-cycle pulse at end of stop bit
module cmd_uart_if
  import cmd_uart_pkg::*;
#(
  parameter int BAUD_DIV     = 1736,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int CNT_W = $clog2(BAUD_DIV);

  logic             rx_meta_q, rx_sync_q;
  uart_state_t      rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             rx_done_s;
  logic             accept_s;

  logic [15:0]      cmd_q, cmd_d;
  logic             rdy_q, rdy_d;
  logic             flag_q, flag_d;

`ifdef CMD_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int TO_W     = $clog2(TO_LIMIT);
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
`endif

  // Two-flop synchronizer, deserializer and command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
      cmd_q      <= 16'h0000;
      rdy_q      <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      cmd_q      <= cmd_d;
      rdy_q      <= rdy_d;
      flag_q     <= flag_d;
    end
  end

`ifdef CMD_TIMEOUT_EN
  // High-byte age counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  // RX FSM: mid-bit sampling, first sample BAUD_DIV/2 after the falling edge.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_done_s  = 1'b0;
    case (rx_state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          rx_cnt_d   = CNT_W'(BAUD_DIV / 2);
          rx_state_d = START;
        end else begin
          rx_cnt_d = rx_cnt_q;
        end
      end
      START: begin
        if (rx_cnt_q == '0) begin
          if (rx_sync_q) begin
            rx_state_d = IDLE;
          end else begin
            rx_bit_d   = 3'd0;
            rx_cnt_d   = CNT_W'(BAUD_DIV - 1);
            rx_state_d = DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (rx_cnt_q == '0) begin
          rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
          rx_cnt_d = CNT_W'(BAUD_DIV - 1);
          if (rx_bit_q == 3'(DATA_BITS - 1)) begin
            rx_state_d = STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (rx_cnt_q == '0) begin
          // A low stop bit is a framing error: the byte is simply not reported.
          rx_done_s  = rx_sync_q;
          rx_state_d = IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        rx_state_d = IDLE;
      end
    endcase
  end

  // Bytes are only taken while no command is pending, so cmd stays stable
  // for the consumer; with cmd_rdy high a clear and a new byte in the same
  // cycle therefore drops the byte.
  assign accept_s = rx_done_s & ~rdy_q;

  // Command assembly and cmd_rdy handshake.
  always_comb begin
    cmd_d  = cmd_q;
    rdy_d  = rdy_q;
    flag_d = flag_q;
    if (clr_cmd_rdy) begin
      rdy_d = 1'b0;
    end else begin
      rdy_d = rdy_q;
    end
`ifdef CMD_TIMEOUT_EN
    // Counter idles at zero, so it restarts on every accepted high byte.
    if (flag_q) begin
      if (to_cnt_q == TO_W'(TO_LIMIT - 1)) begin
        flag_d   = 1'b0;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
`endif
    // A low byte completing in the timeout cycle still forms a command.
    if (accept_s) begin
      if (!flag_q) begin
        cmd_d[15:8] = rx_sh_q;
        flag_d      = 1'b1;
      end else begin
        cmd_d[7:0] = rx_sh_q;
        flag_d     = 1'b0;
        rdy_d      = 1'b1;
      end
    end else begin
      cmd_d = cmd_q;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = rdy_q;

  uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (resp),
    .trmt    (send_resp),
    .TX      (TX),
    .tx_done (resp_sent)
  );

endmodule
